toy_pe44_feeder: RTL and testbench

- Upstream sequencer and skew stage for the 4x4 output-stationary PE array wrapper.
- Accepts unskewed per-K-step A-column and B-row vectors over a valid/ready stream and drives diagonally skewed row and column data, a common din_en, and the load_en/shift_en result-readout sequence.
- One job = one start pulse = k_len K-steps, followed by drain, load and shift-out.

---
 rtl/toy_pe44_feeder.sv | 169 ++++++++++++++++
 tb/tb_toy_pe44_feeder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_pe44_feeder.sv
// toy_pe44_feeder: sequences one job of k_len K-steps into the 4x4 PE array.
// Skews lane i of the A-column / B-row stream by i cycles, then runs the
// drain, load and shift-out readout sequence and pulses done.
// Optional: define TOY_FEEDER_PERF_EN to add the stall_cnt output.
module toy_pe44_feeder #(
    parameter int LANES     = 4,
    parameter int DAT_WIDTH = 8,
    parameter int KLEN_W    = 16,
    parameter int DRAIN_CYC = 4,
    parameter int SHIFT_CYC = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [KLEN_W-1:0]          k_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*DAT_WIDTH-1:0] a_vec,
    input  logic [LANES*DAT_WIDTH-1:0] b_vec,
    output logic                       din_en,
    output logic [LANES*DAT_WIDTH-1:0] din,
    output logic [LANES*DAT_WIDTH-1:0] din_y,
    output logic                       load_en,
    output logic                       shift_en,
    output logic                       busy,
    output logic                       done
`ifdef TOY_FEEDER_PERF_EN
    ,
    output logic [KLEN_W-1:0]          stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_FEED, S_FLUSH, S_DRAIN, S_LOAD, S_SHIFT
    } state_t;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(LANES - 2);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_CYC - 1);

    state_t            state;
    logic [KLEN_W-1:0] klen_q;
    logic [KLEN_W-1:0] beats;
    logic [CNT_W-1:0]  cnt;
    logic              done_pend;
    logic              accept;
    logic              adv;

    assign in_ready = (state == S_FEED) && (beats < klen_q);
    assign accept   = in_valid && in_ready;
    // Skew lines run while beats or flush zeros are moving; otherwise held at 0.
    assign adv      = (state == S_FEED) || (state == S_FLUSH);
    assign busy     = (state != S_IDLE);

    // Job sequencer; outputs are registered and trail the state by one cycle
    // so din_en lines up with the registered skew-line outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            klen_q    <= '0;
            beats     <= '0;
            cnt       <= '0;
            din_en    <= 1'b0;
            load_en   <= 1'b0;
            shift_en  <= 1'b0;
            done      <= 1'b0;
            done_pend <= 1'b0;
        end else begin
            din_en    <= adv;
            load_en   <= (state == S_LOAD);
            shift_en  <= (state == S_SHIFT);
            done      <= done_pend;
            done_pend <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        klen_q <= k_len;
                        beats  <= '0;
                        if (k_len == '0) done  <= 1'b1;
                        else             state <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (accept) begin
                        beats <= beats + 1'b1;
                        if (beats == klen_q - 1'b1) begin
                            state <= S_FLUSH;
                            cnt   <= '0;
                        end
                    end
                end
                S_FLUSH: begin
                    if (cnt == FLUSH_LAST) begin
                        state <= S_DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state <= S_LOAD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    state <= S_SHIFT;
                    cnt   <= '0;
                end
                S_SHIFT: begin
                    if (cnt == SHIFT_LAST) begin
                        state     <= S_IDLE;
                        done_pend <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Per-lane delay lines: lane i holds i+1 stages, so lane 0 is a single
    // register and lane i trails lane 0 by exactly i cycles. A bubble enters
    // as zero on every lane, keeping row and column products aligned.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [i:0][DAT_WIDTH-1:0] sr_a;
        logic [i:0][DAT_WIDTH-1:0] sr_b;
        logic [DAT_WIDTH-1:0]      a_in;
        logic [DAT_WIDTH-1:0]      b_in;

        assign a_in = accept ? a_vec[i*DAT_WIDTH +: DAT_WIDTH] : '0;
        assign b_in = accept ? b_vec[i*DAT_WIDTH +: DAT_WIDTH] : '0;

        // Shift while feeding/flushing, clear otherwise so drain sees zeros.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr_a <= '0;
                sr_b <= '0;
            end else if (adv) begin
                sr_a[0] <= a_in;
                sr_b[0] <= b_in;
                for (int j = 1; j <= i; j++) begin
                    sr_a[j] <= sr_a[j-1];
                    sr_b[j] <= sr_b[j-1];
                end
            end else begin
                sr_a <= '0;
                sr_b <= '0;
            end
        end

        assign din[i*DAT_WIDTH +: DAT_WIDTH]   = sr_a[i];
        assign din_y[i*DAT_WIDTH +: DAT_WIDTH] = sr_b[i];
    end

`ifdef TOY_FEEDER_PERF_EN
    // Counts FEED cycles where the feeder waited on upstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         stall_cnt <= '0;
        else if (state == S_IDLE && start)  stall_cnt <= '0;
        else if (in_ready && !in_valid)     stall_cnt <= stall_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_toy_pe44_feeder.sv
// Directed bench for toy_pe44_feeder: per-cycle output logs checked against
// hand-derived timelines and a small output-stationary array model.
module tb_toy_pe44_feeder;

    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int KW    = 16;
    localparam int NLOG  = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [KW-1:0]    k_len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      a_vec = '0;
    logic [31:0]      b_vec = '0;
    logic             din_en;
    logic [31:0]      din;
    logic [31:0]      din_y;
    logic             load_en;
    logic             shift_en;
    logic             busy;
    logic             done;
`ifdef TOY_FEEDER_PERF_EN
    logic [KW-1:0]    stall_cnt;
`endif

    toy_pe44_feeder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .k_len    (k_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_vec    (a_vec),
        .b_vec    (b_vec),
        .din_en   (din_en),
        .din      (din),
        .din_y    (din_y),
        .load_en  (load_en),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done)
`ifdef TOY_FEEDER_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic        l_en [NLOG];
    logic        l_ld [NLOG];
    logic        l_sh [NLOG];
    logic        l_dn [NLOG];
    logic        l_bz [NLOG];
    logic [31:0] l_din  [NLOG];
    logic [31:0] l_diny [NLOG];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] a_of(input int mode, input int beat);
        logic [31:0] v;
        case (mode)
            0:       v = 32'h04030201;
            1:       v = {4{8'(beat + 1)}};
            default: v = (beat < 4) ? (32'h1 << (8 * beat)) : 32'h0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] b_of(input int mode, input int beat);
        logic [31:0] v;
        case (mode)
            0:       v = 32'h40302010;
            1:       v = {4{8'((beat + 1) * 16)}};
            default: begin
                for (int j = 0; j < 4; j++) v[8*j +: 8] = 8'(4 * beat + j + 1);
            end
        endcase
        return v;
    endfunction

    function automatic logic sig(input int sel, input int t);
        case (sel)
            0:       return l_en[t];
            1:       return l_ld[t];
            2:       return l_sh[t];
            3:       return l_dn[t];
            default: return l_bz[t];
        endcase
    endfunction

    function automatic int cnt(input int sel, input int ncyc);
        int c = 0;
        for (int t = 0; t < ncyc; t++) if (sig(sel, t)) c++;
        return c;
    endfunction

    function automatic int first(input int sel, input int ncyc);
        for (int t = 0; t < ncyc; t++) if (sig(sel, t)) return t;
        return -1;
    endfunction

    function automatic int first_nz(input int lane, input int ncyc);
        for (int t = 0; t < ncyc; t++) if (l_din[t][8*lane +: 8] != 8'h0) return t;
        return -1;
    endfunction

    function automatic int overlaps(input int ncyc);
        int c = 0;
        for (int t = 0; t < ncyc; t++)
            if ((int'(l_en[t]) + int'(l_ld[t]) + int'(l_sh[t])) > 1) c++;
        return c;
    endfunction

    // One job: log index 0 is the cycle start is high; s2 re-asserts start
    // (with k_len=9) at that log index to probe start-while-busy.
    task automatic job(input int k, input logic [31:0] vpat, input int npat,
                       input int mode, input int ncyc, input int s2);
        int beat = 0;
        for (int n = 0; n < ncyc; n++) begin
            start    = (n == 0) || (n == s2);
            k_len    = (n == s2) ? 16'd9 : 16'(k);
            in_valid = (n >= 1 && n - 1 < npat) ? vpat[n-1] : 1'b0;
            a_vec    = a_of(mode, beat);
            b_vec    = b_of(mode, beat);
            @(negedge clk);
            l_en[n]   = din_en;
            l_ld[n]   = load_en;
            l_sh[n]   = shift_en;
            l_dn[n]   = done;
            l_bz[n]   = busy;
            l_din[n]  = din;
            l_diny[n] = din_y;
            if (in_valid && in_ready) beat++;
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        int dc;
        logic [31:0] acc [4][4];

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outs", {busy, in_ready, din_en, load_en, shift_en, done}, 6'b0);
        chk("rst_din", {din, din_y}, 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // No-bubble job, k_len=4
        job(4, 32'hFFFF_FFFF, 32, 0, 24, -1);
        chk("t1_den_cnt",     cnt(0, 24), 7);
        chk("t1_den_first",   first(0, 24), 2);
        chk("t1_lane0_first", first_nz(0, 24), 2);
        chk("t1_lane3_first", first_nz(3, 24), 5);
        chk("t1_lane3_val",   l_din[5][31:24], 8'h04);
        chk("t1_diny_lane3",  l_diny[5][31:24], 8'h40);
        chk("t1_drain_zero",  {l_din[9], l_diny[9]}, 64'h0);
        chk("t1_load_first",  first(1, 24), 13);
        chk("t1_load_cnt",    cnt(1, 24), 1);
        chk("t1_shift_first", first(2, 24), 14);
        chk("t1_shift_cnt",   cnt(2, 24), 4);
        chk("t1_done_first",  first(3, 24), 18);
        chk("t1_done_cnt",    cnt(3, 24), 1);
        chk("t1_busy_feed",   l_bz[1], 1'b1);
        chk("t1_overlap",     overlaps(24), 0);
`ifdef TOY_FEEDER_PERF_EN
        chk("t1_stall", stall_cnt, 16'd0);
`endif

        // Bubbles: k_len=3, in_valid 1,0,1,0,1
        job(3, 32'b10101, 5, 1, 24, -1);
        chk("t2_den_cnt",    cnt(0, 24), 8);
        chk("t2_l0_beat1",   l_din[2][7:0], 8'h01);
        chk("t2_l0_bubble",  l_din[3][7:0], 8'h00);
        chk("t2_l0_beat2",   l_din[4][7:0], 8'h02);
        chk("t2_l3_bubble",  l_din[6][31:24], 8'h00);
        chk("t2_l3_beat2",   l_din[7][31:24], 8'h02);
        chk("t2_l3_beat3",   l_din[9][31:24], 8'h03);
        chk("t2_y2_beat3",   l_diny[8][23:16], 8'h30);
        chk("t2_done_first", first(3, 24), 19);
        chk("t2_overlap",    overlaps(24), 0);
`ifdef TOY_FEEDER_PERF_EN
        chk("t2_stall", stall_cnt, 16'd2);
`endif

        // End-to-end through an output-stationary array model: A=I, B=1..16
        job(4, 32'hFFFF_FFFF, 32, 2, 24, -1);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc[i][j] = '0;
                for (int t = 0; t < 24; t++)
                    if (t - j >= 0 && t - i >= 0)
                        acc[i][j] += 32'(l_din[t-j][8*i +: 8]) * 32'(l_diny[t-i][8*j +: 8]);
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                chk($sformatf("t3_acc_%0d%0d", i, j), acc[i][j], 32'(4 * i + j + 1));

        // Zero-length job
        job(0, 32'h0, 0, 0, 8, -1);
        chk("t4_done_next", l_dn[1], 1'b1);
        chk("t4_done_cnt",  cnt(3, 8), 1);
        chk("t4_quiet",     cnt(0, 8) + cnt(1, 8) + cnt(2, 8) + cnt(4, 8), 0);

        // start with k_len=9 mid-FEED is ignored
        job(4, 32'hFFFF_FFFF, 32, 0, 30, 2);
        chk("t5_den_cnt",    cnt(0, 30), 7);
        chk("t5_shift_cnt",  cnt(2, 30), 4);
        chk("t5_done_cnt",   cnt(3, 30), 1);
        chk("t5_done_first", first(3, 30), 18);

        // Reset during SHIFT
        job(2, 32'hFFFF_FFFF, 32, 0, 13, -1);
        chk("t6_pre_shift", {shift_en, busy}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("t6_async_outs", {busy, in_ready, din_en, load_en, shift_en, done}, 6'b0);
        chk("t6_async_din", {din, din_y}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dc = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done) dc++;
        end
        chk("t6_no_done", dc, 0);
        chk("t6_idle", busy, 1'b0);
        @(posedge clk);
        #1;
        job(4, 32'hFFFF_FFFF, 32, 0, 24, -1);
        chk("t6_den_cnt",    cnt(0, 24), 7);
        chk("t6_done_first", first(3, 24), 18);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
